circle_octant_plotter: RTL
==========================

// Module: circle_octant_plotter
// PURPOSE
//  Parametrised successor to the fixed-size lab circle/triangle drawer. Draws a midpoint-algorithm
//  circle outline, one pixel per cycle, on the VGA pixel-write interface of the lab framebuffer
//  adapter. Screen size, coordinate widths and colour depth are parameters. A per-request
//  octant mask selects which of the 8 arcs are drawn, so one engine also builds arcs and partial shapes.
// PARAMETERS
//  SCREEN_W  160  visible width; x in [0,SCREEN_W-1]
//  SCREEN_H  120  visible height; y in [0,SCREEN_H-1]
//  XW        8    x coordinate width
//  YW        7    y coordinate width
//  RW        8    radius width
//  CW        3    colour width
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous, active-low reset
//  start        in   1   request; level-sensitive, see handshake
//  colour       in   CW  outline colour, latched at start
//  centre_x     in   XW  centre x, latched at start
//  centre_y     in   YW  centre y, latched at start
//  radius       in   RW  radius, latched at start
//  octant_mask  in   8   bit k enables octant k, latched at start
//  done         out  1   request complete
//  vga_x        out  XW  pixel x
//  vga_y        out  YW  pixel y
//  vga_colour   out  CW  pixel colour
//  vga_plot     out  1   pixel write strobe, 1 cycle per pixel
// BEHAVIOUR
//  - Single clock clk. Reset is asynchronous, active-low (rst_n).
//  - Reset, asserted at any time, including mid-draw: state=IDLE. done, vga_plot, vga_x, vga_y and vga_colour are all 0.
//    The partially drawn request is abandoned.
//  - FSM: IDLE -> [CLEAR] -> PLOT -> DONE -> IDLE.
//  - IDLE:
//    - On the first clk with start=1, latch all inputs.
//    - Set ox=radius, oy=0, crit=1-radius, oct=0.
//  - PLOT: one cycle per octant slot, oct counts 0..7. Arithmetic is signed, width max(XW,YW,RW)+2.
//    - Pixel for each slot:
//      - 0:(cx+ox,cy+oy)   1:(cx+oy,cy+ox)   2:(cx-oy,cy+ox)   3:(cx-ox,cy+oy)
//      - 4:(cx-ox,cy-oy)   5:(cx-oy,cy-ox)   6:(cx+oy,cy-ox)   7:(cx+ox,cy-oy)
//    - vga_plot=1 only when all of: octant_mask[oct]=1, 0<=x<SCREEN_W, 0<=y<SCREEN_H.
//    - Masked-off and clipped slots still take their cycle, with vga_plot=0. Timing is independent of mask and position.
//    - On the oct=7 cycle, step the circle and wrap oct to 0:
//      - oy+=1;
//      - if crit<=0: crit+=2*oy+1 (oy = new value);
//      - else: ox-=1, crit+=2*(oy-ox)+1 (oy, ox = new values).
//    - If the new oy > new ox, go to DONE instead of wrapping.
//  - Latency: 8 cycles per iteration. done rises the cycle after the final slot.
//    - radius=0: exactly 1 iteration, 8 slots all at the centre. Duplicate writes are allowed.
//    - Duplicate pixels on the 45-degree diagonal and on the axes are allowed.
//  - DONE: done=1, vga_plot=0.
//    - Hold until start=0, then IDLE; done falls that same edge.
//    - start held high across done does not retrigger; a new request needs start to be low for at least 1 cycle.
//  - Input changes after latching are ignored until the next request.
// CONFIGURATION
//  - CLEAR_SCREEN_EN defined:
//    - Every request first enters CLEAR: writes colour 0 to all pixels with vga_plot=1, y outer, x inner.
//    - x wraps SCREEN_W-1 -> 0 with y+1. Takes SCREEN_W*SCREEN_H cycles (19200 at defaults), then PLOT.
//  - CLEAR_SCREEN_EN undefined: CLEAR does not exist; IDLE goes straight to PLOT.
// TESTING
//  1. c=(80,60), r=0, mask=FF: 8 plots at (80,60); done 9 cycles after the start edge (no clear).
//  2. c=(80,60), r=10, mask=01: plots only in slot 0; first pixel (90,60); no pixel with y<60.
//  3. c=(2,2), r=5, mask=FF: no vga_plot with x or y negative; iteration count equals the unclipped case.
//  4. start held 5 cycles after done: done stays 1, no new plots; start=0 -> done=0 next edge; restart works.
//  5. rst_n=0 mid-PLOT at c=(80,60), r=40: all outputs 0 immediately; next request redraws from slot 0.
//  6. CLEAR_SCREEN_EN: 19200 black plots, first (0,0), x 159 -> 0 with y+1, last (159,119), then outline.

Source files
------------

// File: rtl/circle_octant_plotter.sv
// Midpoint circle outline engine driving the lab framebuffer pixel-write port, one octant slot per cycle.
// Optional build macro CLEAR_SCREEN_EN: blank the whole screen to colour 0 before each outline.
module circle_octant_plotter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int RW       = 8,
    parameter int CW       = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] colour,
    input  logic [XW-1:0] centre_x,
    input  logic [YW-1:0] centre_y,
    input  logic [RW-1:0] radius,
    input  logic [7:0]    octant_mask,
    output logic          done,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot
);
    localparam int AW  = ((XW > YW) ? ((XW > RW) ? XW : RW) : ((YW > RW) ? YW : RW)) + 2;
    // crit swings to roughly +/-2*radius, so it gets extra headroom over the coordinates
    localparam int CRW = AW + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLOT  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
`ifdef CLEAR_SCREEN_EN
    localparam logic [1:0] S_CLEAR = 2'd3;
`endif

    localparam logic signed [AW-1:0]  ONE    = AW'(1);
    localparam logic signed [CRW-1:0] CR_ONE = CRW'(1);
    localparam logic signed [AW-1:0]  SW     = AW'(SCREEN_W);
    localparam logic signed [AW-1:0]  SH     = AW'(SCREEN_H);

    logic [1:0]            state;
    logic [CW-1:0]         col;
    logic [XW-1:0]         cx;
    logic [YW-1:0]         cy;
    logic [7:0]            mask;
    logic signed [AW-1:0]  ox, oy;
    logic signed [CRW-1:0] crit;
    logic [2:0]            oct;

`ifdef CLEAR_SCREEN_EN
    logic [XW-1:0] clr_x;
    logic [YW-1:0] clr_y;
`endif

    logic signed [AW-1:0]  cxs, cys, px, py, ox_n, oy_n;
    logic signed [CRW-1:0] crit_n;
    logic                  plot_en, finish, crit_pos;

    assign cxs = signed'({{(AW-XW){1'b0}}, cx});
    assign cys = signed'({{(AW-YW){1'b0}}, cy});

    always_comb begin
        px = cxs + ox;
        py = cys + oy;
        case (oct)
            3'd0: begin px = cxs + ox; py = cys + oy; end
            3'd1: begin px = cxs + oy; py = cys + ox; end
            3'd2: begin px = cxs - oy; py = cys + ox; end
            3'd3: begin px = cxs - ox; py = cys + oy; end
            3'd4: begin px = cxs - ox; py = cys - oy; end
            3'd5: begin px = cxs - oy; py = cys - ox; end
            3'd6: begin px = cxs + oy; py = cys - ox; end
            default: begin px = cxs + ox; py = cys - oy; end
        endcase
        plot_en = mask[oct] && !px[AW-1] && (px < SW) && !py[AW-1] && (py < SH);
    end

    always_comb begin
        crit_pos = !crit[CRW-1] && (crit != '0);
        oy_n     = oy + ONE;
        ox_n     = crit_pos ? (ox - ONE) : ox;
        crit_n   = crit_pos ? (crit + ((CRW'(oy_n) - CRW'(ox_n)) <<< 1) + CR_ONE)
                            : (crit + (CRW'(oy_n) <<< 1) + CR_ONE);
        finish   = (oy_n > ox_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            col        <= '0;
            cx         <= '0;
            cy         <= '0;
            mask       <= '0;
            ox         <= '0;
            oy         <= '0;
            crit       <= '0;
            oct        <= '0;
            done       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
`ifdef CLEAR_SCREEN_EN
            clr_x      <= '0;
            clr_y      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    vga_plot <= 1'b0;
                    if (start) begin
                        col   <= colour;
                        cx    <= centre_x;
                        cy    <= centre_y;
                        mask  <= octant_mask;
                        ox    <= signed'({{(AW-RW){1'b0}}, radius});
                        oy    <= '0;
                        crit  <= CR_ONE - signed'({{(CRW-RW){1'b0}}, radius});
                        oct   <= '0;
`ifdef CLEAR_SCREEN_EN
                        clr_x <= '0;
                        clr_y <= '0;
                        state <= S_CLEAR;
`else
                        state <= S_PLOT;
`endif
                    end
                end
`ifdef CLEAR_SCREEN_EN
                S_CLEAR: begin
                    vga_x      <= clr_x;
                    vga_y      <= clr_y;
                    vga_colour <= '0;
                    vga_plot   <= 1'b1;
                    if (clr_x == XW'(SCREEN_W - 1)) begin
                        clr_x <= '0;
                        if (clr_y == YW'(SCREEN_H - 1)) state <= S_PLOT;
                        else clr_y <= clr_y + 1'b1;
                    end else begin
                        clr_x <= clr_x + 1'b1;
                    end
                end
`endif
                S_PLOT: begin
                    vga_x      <= px[XW-1:0];
                    vga_y      <= py[YW-1:0];
                    vga_colour <= col;
                    vga_plot   <= plot_en;
                    oct        <= oct + 3'd1;
                    if (oct == 3'd7) begin
                        ox   <= ox_n;
                        oy   <= oy_n;
                        crit <= crit_n;
                        if (finish) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // done is raised one cycle after entry so it lines up after the last registered pixel
                    vga_plot <= 1'b0;
                    if (!done) begin
                        done <= 1'b1;
                    end else if (!start) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
